mux_scan: RTL and testbench

- Parametrised N:1 data selector with a registered output.
- Two modes: manual, where an external select picks the channel, and scan, where an internal sequencer steps through every channel round-robin and holds each one for a programmable number of cycles.
- Used to time-multiplex several sensor or data channels onto one downstream bus, with a valid flag and a wrap marker.

---
 rtl/mux_scan.sv | 110 +++++++++++
 tb/tb_mux_scan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// N:1 channel selector with registered output: manual select or round-robin scan
// holding each channel for DWELL cycles, with valid flag and wrap marker.
module mux_scan #(
  parameter int DW    = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH),
  parameter int DWELL = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NCH*DW-1:0]   i_d,
  input  logic                i_en,
  input  logic                i_mode,
  input  logic [SELW-1:0]     i_sel,
  output logic [DW-1:0]       o_y,
  output logic [SELW-1:0]     o_sel,
  output logic                o_valid,
  output logic                o_wrap
);

  localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic [DWW-1:0]    dw_q, dw_d;
  logic [DW-1:0]     y_q, y_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  logic [SELW-1:0]   pick;
  logic [DW-1:0]     pick_data;
  logic              pick_ok;

  always_comb begin
    pick      = (state_d == SCAN) ? ch_q : i_sel;
    pick_data = '0;
    pick_ok   = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (pick == SELW'(k)) begin
        pick_data = i_d[k*DW +: DW];
        pick_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = i_en ? (i_mode ? SCAN : MAN) : IDLE;
    ch_d    = '0;
    dw_d    = '0;
    y_d     = y_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    case (state_d)
      MAN: begin
        y_d     = pick_ok ? pick_data : '0;
        sel_d   = i_sel;
        valid_d = pick_ok;
      end
      SCAN: begin
        y_d     = pick_data;
        sel_d   = ch_q;
        valid_d = 1'b1;
        // Counters are cleared outside SCAN, so ch=0/dw=0 while already scanning means a wrap
        wrap_d  = (state_q == SCAN) && (ch_q == '0) && (dw_q == '0);
        ch_d    = ch_q;
        if (dw_q == DWW'(DWELL - 1)) begin
          dw_d = '0;
          ch_d = (ch_q == SELW'(NCH - 1)) ? '0 : ch_q + SELW'(1);
        end else begin
          dw_d = dw_q + DWW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      dw_q    <= '0;
      y_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dw_q    <= dw_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_y     = y_q;
  assign o_sel   = sel_q;
  assign o_valid = valid_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: vector table, hand sequences, and random stimulus against a
// cycle-count reference model (NCH=4/DWELL=4 instance) plus an NCH=3/DWELL=1 instance.
module tb_mux_scan;

  localparam int NCH_A   = 4;
  localparam int DWELL_A = 4;

  logic        clk;
  logic        rst_n;

  logic [31:0] a_d;
  logic        a_en, a_mode;
  logic [1:0]  a_sel;
  logic [7:0]  a_y;
  logic [1:0]  a_sel_o;
  logic        a_valid, a_wrap;

  logic [23:0] b_d;
  logic        b_en, b_mode;
  logic [1:0]  b_sel;
  logic [7:0]  b_y;
  logic [1:0]  b_sel_o;
  logic        b_valid, b_wrap;

  int n_pass  = 0;
  int n_total = 0;

  int        m_t;
  bit [7:0]  m_y;
  int        m_sel;
  bit        m_valid, m_wrap;

  typedef struct {
    bit        en;
    bit        mode;
    bit [1:0]  sel;
    bit [31:0] d;
    int        ey;
    int        esel;
    bit        ev;
    bit        ew;
  } vec_t;

  vec_t tbl[$];

  mux_scan #(.DW(8), .NCH(NCH_A), .DWELL(DWELL_A)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(a_d), .i_en(a_en), .i_mode(a_mode),
    .i_sel(a_sel), .o_y(a_y), .o_sel(a_sel_o), .o_valid(a_valid), .o_wrap(a_wrap)
  );

  mux_scan #(.DW(8), .NCH(3), .DWELL(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(b_d), .i_en(b_en), .i_mode(b_mode),
    .i_sel(b_sel), .o_y(b_y), .o_sel(b_sel_o), .o_valid(b_valid), .o_wrap(b_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_t = 0; m_y = '0; m_sel = 0; m_valid = 0; m_wrap = 0;
  endtask

  // Scan output derived from the number of samples produced since scan entry
  task automatic model_step();
    int c;
    if (!a_en) begin
      m_valid = 0; m_wrap = 0; m_t = 0;
    end else if (!a_mode) begin
      m_t = 0; m_y = a_d[a_sel*8 +: 8]; m_sel = a_sel; m_valid = 1; m_wrap = 0;
    end else begin
      c       = (m_t / DWELL_A) % NCH_A;
      m_y     = a_d[c*8 +: 8];
      m_sel   = c;
      m_valid = 1;
      m_wrap  = (m_t > 0) && (m_t % (NCH_A * DWELL_A) == 0);
      m_t++;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input int ey, input int es, input int ev, input int ew);
    chk({nm, ".y"},     a_y,     ey);
    chk({nm, ".sel"},   a_sel_o, es);
    chk({nm, ".valid"}, a_valid, ev);
    chk({nm, ".wrap"},  a_wrap,  ew);
  endtask

  initial begin
    rst_n  = 1'b0;
    a_en = 1'b1; a_mode = 1'b1; a_sel = '0; a_d = 32'hA5C3_7E19;
    b_en = 1'b0; b_mode = 1'b0; b_sel = '0; b_d = 24'h0;
    model_reset();

    // Vector table
    for (int s = 0; s < 4; s++) begin
      tbl.push_back('{1'b1, 1'b0, 2'(s), 32'h0302_0100, s, s, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2'(s), 32'h0302_0100, s, s, 1'b1, 1'b0});
    end
    tbl.push_back('{1'b1, 1'b0, 2'd2, 32'h0306_0100, 6,  2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 2'd2, 32'h0306_0100, 6,  2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 2'd2, 32'h030A_0100, 10, 2, 1'b1, 1'b0});
    for (int i = 0; i < 17; i++)
      tbl.push_back('{1'b1, 1'b1, 2'd3, 32'h0B0A_0908, 8 + (i/4)%4, (i/4)%4, 1'b1, bit'(i == 16)});
    tbl.push_back('{1'b0, 1'b1, 2'd3, 32'h0B0A_0908, 8, 0, 1'b0, 1'b0});

    // Reset held with scan requested
    repeat (3) begin
      @(posedge clk); #1;
      chk_a("reset", 0, 0, 0, 0);
      chk("reset.b_valid", b_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_a("post_reset", 8'h19, 0, 1, 0);

    foreach (tbl[i]) begin
      a_en = tbl[i].en; a_mode = tbl[i].mode; a_sel = tbl[i].sel; a_d = tbl[i].d;
      step();
      chk_a($sformatf("tbl%0d", i), tbl[i].ey, tbl[i].esel, tbl[i].ev, tbl[i].ew);
    end

    // Mode switch mid-dwell: sample 9 is channel 2, second dwell cycle
    a_en = 1; a_mode = 1; a_d = 32'h4433_2211;
    repeat (10) step();
    chk_a("mid_dwell", 8'h33, 2, 1, 0);
    a_mode = 0; a_sel = 2'd1;
    step();
    chk_a("to_manual", 8'h22, 1, 1, 0);
    a_mode = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_a("rescan_ch0", 8'h11, 0, 1, 0);
    end
    step();
    chk_a("rescan_ch1", 8'h22, 1, 1, 0);

    a_en = 0;
    step();
    chk_a("en_drop", 8'h22, 1, 0, 0);
    a_en = 1;
    step();
    chk_a("re_enable", 8'h11, 0, 1, 0);

    // Asynchronous reset mid-scan
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_a("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_a("after_async", 8'h11, 0, 1, 0);

    // NCH=3, DWELL=1 instance
    b_en = 1; b_mode = 1; b_d = 24'h1E_140A;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b_scan.y",    b_y,     10 * ((i % 3) + 1));
      chk("b_scan.sel",  b_sel_o, i % 3);
      chk("b_scan.wrap", b_wrap,  int'(i == 3));
    end
    b_mode = 0; b_sel = 2'd3;
    step();
    chk("b_oob.y",     b_y,     0);
    chk("b_oob.sel",   b_sel_o, 3);
    chk("b_oob.valid", b_valid, 0);
    b_sel = 2'd2;
    step();
    chk("b_man.y",     b_y,     30);
    chk("b_man.valid", b_valid, 1);

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) a_en = ~a_en;
      else if (!a_en && $urandom_range(0, 3) == 0) a_en = 1;
      if ($urandom_range(0, 39) == 0) a_mode = ~a_mode;
      a_sel = 2'($urandom);
      if ($urandom_range(0, 2) == 0) a_d = $urandom;
      step();
      chk_a("rand", m_y, m_sel, m_valid, m_wrap);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
